// File: rtl/audio_pkg.sv
// audio_pkg: shared types, note tuning table and note priority encoder for the
// audio transmit path (audio_pwm_tx and its pwm_dac).
//   state_t      - transmit FSM state, encoding matches the 7-seg debug value
//   NOTE_TUNING  - 24-bit phase increment per note, index 0 = C4 .. 6 = B4
//   note_encode  - one-hot (or multi-hot) note request -> {valid, index}
package audio_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRampUp   = 2'd1,
    StPlay     = 2'd2,
    StRampDown = 2'd3
  } state_t;

  localparam int NUM_NOTES   = 7;
  localparam int TUNING_BITS = 24;

  // Phase increments for a 390.625 kHz sample rate and a 2**24 phase circle.
  localparam logic [TUNING_BITS-1:0] NOTE_TUNING [NUM_NOTES] = '{
    24'd11237,  // C4
    24'd12613,  // D4
    24'd14158,  // E4
    24'd14999,  // F4
    24'd16836,  // G4
    24'd18898,  // A4
    24'd21212   // B4
  };

  localparam logic [3:0] ENV_MAX = 4'd15;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } note_sel_t;

  // Lowest set bit wins, so a multi-hot request resolves to the lowest note.
  function automatic note_sel_t note_encode(input logic [NUM_NOTES-1:0] note);
    note_sel_t sel;
    sel = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (note[i]) begin
        sel.valid = 1'b1;
        sel.idx   = 3'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pwm_dac.sv
// pwm_dac: free-running PWM counter with a per-period sample register.
//   clk_in     in   system clock
//   rst_n_in   in   asynchronous active-low reset
//   sample_in  in   next sample, captured on the tick
//   enable_in  in   0 forces the PWM output low
//   tick_out   out  high on the last count of each PWM period (sample tick)
//   pwm_out    out  registered (pwm_cnt < sample_q) gated by enable_in
module pwm_dac
  import audio_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [PWM_BITS-1:0] sample_in,
  input  logic                enable_in,
  output logic                tick_out,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] sample_q;
  logic                pwm_q;

  assign tick_out = (pwm_cnt_q == {PWM_BITS{1'b1}});
  assign pwm_out  = pwm_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pwm_cnt_q <= '0;
      sample_q  <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (tick_out) begin
        sample_q <= sample_in;
      end
      pwm_q <= enable_in && (pwm_cnt_q < sample_q);
    end
  end

endmodule

// File: rtl/audio_pwm_tx.sv
// audio_pwm_tx: enveloped square-wave tone generator driving the board
// amplifier through a 1-bit PWM stream.
//   clk_in          in   100 MHz system clock
//   rst_n_in        in   asynchronous active-low reset
//   note_in         in   one-hot note request, bit0 = C4 .. bit6 = B4, 0 = stop
//   note_valid_in   in   note_in valid this cycle
//   note_ready_out  out  note accepted when valid && ready (low only in RAMP_DOWN)
//   volume_in       in   linear volume 0..15, sampled at each sample tick
//   aud_pwm_out     out  PWM audio bit
//   aud_sd_out      out  amplifier enable, high whenever the FSM is not idle
//   state_out       out  FSM state for debug display
module audio_pwm_tx
  import audio_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PHASE_BITS = 24,
  parameter int unsigned RAMP_DIV   = 64
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [6:0] note_in,
  input  logic       note_valid_in,
  output logic       note_ready_out,
  input  logic [3:0] volume_in,
  output logic       aud_pwm_out,
  output logic       aud_sd_out,
  output logic [1:0] state_out
);

  localparam int unsigned         DIV_W      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] SAMPLE_MID = {1'b1, {(PWM_BITS - 1){1'b0}}};

  state_t                state_q, state_d;
  logic [3:0]            env_q, env_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [PHASE_BITS-1:0] tuning_q, tuning_d;
  logic [PHASE_BITS-1:0] pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  sd_q;

  logic                  tick;
  logic                  step;
  logic                  accept;
  note_sel_t             note_sel;
  logic [PHASE_BITS-1:0] note_word;
  logic [PHASE_BITS-1:0] eff_tuning;
  logic [7:0]            amp;
  logic [PWM_BITS-1:0]   sample;
  logic                  pwm_enable;

  assign note_ready_out = (state_q != StRampDown);
  assign accept         = note_valid_in && note_ready_out;
  assign note_sel       = note_encode(note_in);
  assign note_word      = PHASE_BITS'(NOTE_TUNING[note_sel.idx]);
  // A pending note change is applied exactly at a tick, so the phase never jumps.
  assign eff_tuning     = pend_vld_q ? pend_q : tuning_q;
  assign step           = tick && (div_q == DIV_LAST);

  assign aud_sd_out = sd_q;
  assign state_out  = state_q;
  assign pwm_enable = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    env_d      = env_q;
    phase_d    = phase_q;
    tuning_d   = tuning_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    div_d      = div_q;

    if (tick) begin
      phase_d    = phase_q + eff_tuning;
      tuning_d   = eff_tuning;
      pend_vld_d = 1'b0;
      div_d      = step ? '0 : div_q + DIV_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept && note_sel.valid) begin
          state_d    = StRampUp;
          tuning_d   = note_word;
          phase_d    = '0;
          pend_vld_d = 1'b0;
          env_d      = '0;
          div_d      = '0;
        end
      end
      StRampUp: begin
        if (step) begin
          env_d = env_q + 4'd1;
          if (env_q == ENV_MAX - 4'd1) begin
            state_d = StPlay;
          end
        end
        if (accept) begin
          if (note_sel.valid) begin
            pend_d     = note_word;
            pend_vld_d = 1'b1;
          end else begin
            // Fade out from wherever the ramp currently is.
            state_d = StRampDown;
            env_d   = env_q;
            div_d   = '0;
          end
        end
      end
      StPlay: begin
        if (accept) begin
          if (note_sel.valid) begin
            pend_d     = note_word;
            pend_vld_d = 1'b1;
          end else begin
            state_d = StRampDown;
            div_d   = '0;
          end
        end
      end
      StRampDown: begin
        if (env_q == '0) begin
          state_d = StIdle;
        end else if (step) begin
          env_d = env_q - 4'd1;
          if (env_q == 4'd1) begin
            state_d = StIdle;
          end
        end
        if (state_d == StIdle) begin
          env_d      = '0;
          tuning_d   = '0;
          pend_vld_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sample for the coming PWM period uses the phase after this tick's update.
  always_comb begin
    amp = {4'd0, env_q} * {4'd0, volume_in};
    if (phase_d[PHASE_BITS-1]) begin
      sample = SAMPLE_MID + PWM_BITS'(amp[7:1]);
    end else begin
      sample = SAMPLE_MID - PWM_BITS'(amp[7:1]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      env_q      <= '0;
      phase_q    <= '0;
      tuning_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      div_q      <= '0;
      sd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      env_q      <= env_d;
      phase_q    <= phase_d;
      tuning_q   <= tuning_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      div_q      <= div_d;
      sd_q       <= (state_d != StIdle);
    end
  end

  pwm_dac #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_dac (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .sample_in (sample),
    .enable_in (pwm_enable),
    .tick_out  (tick),
    .pwm_out   (aud_pwm_out)
  );

endmodule

// File: tb/tb_audio_pwm_tx.sv
// Bench for audio_pwm_tx. A short phase accumulator and ramp divider keep the
// run short while still exercising the tone, envelope and handshake logic.
module tb_audio_pwm_tx;

  localparam int unsigned PWM_BITS   = 8;
  localparam int unsigned PHASE_BITS = 16;
  localparam int unsigned RAMP_DIV   = 2;
  localparam int          RAMP_TICKS = 15 * RAMP_DIV;
  localparam int          PERIOD     = 256;
  localparam int          VEC_WINS   = 10;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [6:0] note_in = '0;
  logic       note_valid_in = 1'b0;
  logic [3:0] volume_in = '0;
  logic       note_ready_out;
  logic       aud_pwm_out;
  logic       aud_sd_out;
  logic [1:0] state_out;

  audio_pwm_tx #(
    .PWM_BITS  (PWM_BITS),
    .PHASE_BITS(PHASE_BITS),
    .RAMP_DIV  (RAMP_DIV)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .note_in       (note_in),
    .note_valid_in (note_valid_in),
    .note_ready_out(note_ready_out),
    .volume_in     (volume_in),
    .aud_pwm_out   (aud_pwm_out),
    .aud_sd_out    (aud_sd_out),
    .state_out     (state_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [6:0]  note;
    logic [3:0]  vol;
    logic [15:0] tun;
    int          hi;
  } vec_t;

  typedef struct {
    int idx;
    int exp;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];

  // Test-owned controls read by the model.
  logic        chk_en = 1'b0;
  logic [15:0] m_next_tun = '0;
  int          m_hi = 240;

  // Model-owned state.
  int          ecnt;
  int          m_tk;
  logic [15:0] m_phase, m_tun, m_pend;
  logic        m_pend_v;
  logic        m_idle;
  logic        m_ready;
  sb_t         model_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tone phase, pending tuning swap, ramp-down timing.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ecnt = 0; m_tk = 0; m_phase = '0; m_tun = '0; m_pend = '0;
      m_pend_v = 1'b0; m_idle = 1'b1; m_ready = 1'b1;
    end else begin
      ecnt++;
      if (ecnt % PERIOD == 0) begin
        if (m_pend_v) m_tun = m_pend;
        m_pend_v = 1'b0;
        m_phase  = m_phase + m_tun;
        m_tk++;
        if (!m_ready && m_tk == RAMP_TICKS) begin
          m_idle = 1'b1; m_ready = 1'b1; m_tun = '0;
        end
        if (chk_en) begin
          model_e.idx = ecnt / PERIOD;
          model_e.exp = m_idle ? 0 : (m_phase[15] ? m_hi : PERIOD - m_hi);
          sb_q.push_back(model_e);
        end
      end
      if (note_valid_in && m_ready) begin
        if (note_in == 7'd0) begin
          if (!m_idle) begin
            m_tk = 0; m_ready = 1'b0;
          end
        end else if (m_idle) begin
          m_idle = 1'b0; m_tun = m_next_tun; m_phase = '0; m_pend_v = 1'b0; m_tk = 0;
        end else begin
          m_pend = m_next_tun; m_pend_v = 1'b1;
        end
      end
    end
  end

  int  acc = 0;
  sb_t mon_e;

  // Advance n cycles; on every negedge accumulate PWM highs and close windows.
  task automatic cyc(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        acc = 0;
        sb_q.delete();
      end else begin
        acc += int'(aud_pwm_out);
        if (ecnt > 0 && ecnt % PERIOD == 0) begin
          w = ecnt / PERIOD - 1;
          while (sb_q.size() > 0 && sb_q[0].idx < w) void'(sb_q.pop_front());
          if (sb_q.size() > 0 && sb_q[0].idx == w) begin
            mon_e = sb_q.pop_front();
            if (chk_en) check($sformatf("pwm_window_%0d", w), acc, mon_e.exp);
          end
          acc = 0;
        end
      end
    end
  endtask

  task automatic send_note(input logic [6:0] note, input logic [3:0] vol,
                           input logic [15:0] tun, input int hi);
    m_next_tun    = tun;
    m_hi          = hi;
    note_in       = note;
    volume_in     = vol;
    note_valid_in = 1'b1;
    cyc(1);
    note_valid_in = 1'b0;
    note_in       = '0;
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string name);
    int k;
    k = 0;
    while (state_out != target && k < budget) begin
      cyc(1);
      k++;
    end
    check(name, int'(state_out), int'(target));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{7'b0000001, 4'd15, 16'd11237, 240};  // C4
    vecs[1] = '{7'b0000100, 4'd15, 16'd14158, 240};  // E4 swap
    vecs[2] = '{7'b0100000, 4'd9,  16'd18898, 195};  // A4
    vecs[3] = '{7'b1000101, 4'd15, 16'd11237, 240};  // multi-hot -> C4
    vecs[4] = '{7'b1000000, 4'd7,  16'd21212, 180};  // B4
    vecs[5] = '{7'b0000010, 4'd12, 16'd12613, 218};  // D4
    vecs[6] = '{7'b0001000, 4'd3,  16'd14999, 150};  // F4
    vecs[7] = '{7'b0010000, 4'd15, 16'd16836, 240};  // G4
    vecs[8] = '{7'b0010000, 4'd15, 16'd16836, 240};  // G4 re-request
    vecs[9] = '{7'b0000010, 4'd0,  16'd12613, 128};  // D4, volume 0

    cyc(3);
    check("reset_sd", int'(aud_sd_out), 0);
    check("reset_pwm", int'(aud_pwm_out), 0);
    check("reset_ready", int'(note_ready_out), 1);
    check("reset_state", int'(state_out), 0);
    #2 rst_n_in = 1'b1;

    // Idle: PWM stays low for whole windows.
    chk_en = 1'b1;
    cyc(10 * PERIOD);
    check("idle_sd", int'(aud_sd_out), 0);
    check("idle_ready", int'(note_ready_out), 1);
    check("idle_state", int'(state_out), 0);

    // Zero note in idle is ignored.
    send_note(7'd0, 4'd15, 16'd0, 240);
    cyc(3);
    check("zero_in_idle_state", int'(state_out), 0);
    check("zero_in_idle_sd", int'(aud_sd_out), 0);

    // Start A4 and ramp up.
    chk_en = 1'b0;
    send_note(7'b0100000, 4'd15, 16'd18898, 240);
    check("sd_after_accept", int'(aud_sd_out), 1);
    check("state_ramp_up", int'(state_out), 1);
    wait_state(2'd2, RAMP_TICKS * PERIOD + 2 * PERIOD, "reach_play");
    check("ramp_up_ticks", m_tk, RAMP_TICKS);
    chk_en = 1'b1;
    cyc(6 * PERIOD);

    // Note / volume changes while playing.
    for (int v = 0; v < 10; v++) begin
      send_note(vecs[v].note, vecs[v].vol, vecs[v].tun, vecs[v].hi);
      cyc(VEC_WINS * PERIOD);
      check($sformatf("vec%0d_state", v), int'(state_out), 2);
    end

    // Stop: ramp down, new requests refused until idle.
    chk_en = 1'b0;
    send_note(7'd0, 4'd15, 16'd0, 240);
    check("ramp_down_ready", int'(note_ready_out), 0);
    check("ramp_down_state", int'(state_out), 3);
    note_in       = 7'b0100000;
    note_valid_in = 1'b1;
    cyc(4);
    note_valid_in = 1'b0;
    note_in       = '0;
    check("no_accept_state", int'(state_out), 3);
    check("no_accept_ready", int'(note_ready_out), 0);
    wait_state(2'd0, RAMP_TICKS * PERIOD + 2 * PERIOD, "reach_idle");
    check("ramp_down_ticks", m_tk, RAMP_TICKS);
    check("idle_after_stop_sd", int'(aud_sd_out), 0);
    check("idle_after_stop_ready", int'(note_ready_out), 1);
    chk_en = 1'b1;
    cyc(3 * PERIOD);

    // Asynchronous reset in the middle of a ramp-up.
    chk_en = 1'b0;
    send_note(7'b1000000, 4'd15, 16'd21212, 240);
    cyc(5 * PERIOD);
    check("mid_ramp_state", int'(state_out), 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("async_reset_sd", int'(aud_sd_out), 0);
    check("async_reset_pwm", int'(aud_pwm_out), 0);
    check("async_reset_ready", int'(note_ready_out), 1);
    check("async_reset_state", int'(state_out), 0);
    cyc(3);
    #2 rst_n_in = 1'b1;

    // Next note after reset ramps from env 0.
    send_note(7'b0000001, 4'd15, 16'd11237, 240);
    wait_state(2'd2, RAMP_TICKS * PERIOD + 2 * PERIOD, "reach_play_after_reset");
    check("ramp_up_ticks_after_reset", m_tk, RAMP_TICKS);
    chk_en = 1'b1;
    cyc(5 * PERIOD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
